// File: rtl/dii_package.sv
// Shared DII flit definitions.
// dii_flit     : one beat of a DII stream (valid, last, 16-bit data).
// dii_assemble : builds a dii_flit from its individual fields.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    function automatic dii_flit dii_assemble(input logic valid, input logic last, input logic [15:0] data);
        dii_flit f;
        f.valid = valid;
        f.last  = last;
        f.data  = data;
        return f;
    endfunction

endpackage

// File: rtl/dii_packet_arbiter_if.sv
// Bus bundle for the DII packet arbiter.
// in_flit   : N per-channel input flits
// in_ready  : N per-channel accept strobes
// out_flit  : merged output flit
// out_ready : downstream accept
// slave modport is the arbiter side, master modport is the traffic side.
interface dii_packet_arbiter_if
    import dii_package::*;
#(
    parameter int N = 2
);

    dii_flit [N-1:0] in_flit;
    logic    [N-1:0] in_ready;
    dii_flit         out_flit;
    logic            out_ready;

    modport slave (
        input  in_flit,
        input  out_ready,
        output in_ready,
        output out_flit
    );

    modport master (
        output in_flit,
        output out_ready,
        input  in_ready,
        input  out_flit
    );

endinterface

// File: rtl/dii_rr_select.sv
// Round-robin request selector (purely combinational).
// req   : request vector, one bit per channel
// ptr   : channel with highest priority this round
// grant : one-hot winner, first set request at or above ptr (mod N)
// any   : at least one request present
module dii_rr_select #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [N-1:0] req_rot_s;
    logic [N-1:0] grant_rot_s;
    logic         found_s;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot_s   = (req >> ptr) | (req << (N - int'(ptr)));
        grant_rot_s = '0;
        found_s     = 1'b0;
        for (int k = 0; k < N; k++) begin
            grant_rot_s[k] = req_rot_s[k] & ~found_s;
            found_s        = found_s | req_rot_s[k];
        end
        grant = (grant_rot_s << ptr) | (grant_rot_s >> (N - int'(ptr)));
        any   = found_s;
    end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular DII merger: N input channels onto one registered output.
// A channel is picked round-robin in IDLE and keeps the grant until its
// last flit has been accepted; one IDLE arbitration cycle per packet.
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : dii_packet_arbiter_if.slave (in_flit, in_ready, out_flit, out_ready)
module dii_packet_arbiter
    import dii_package::*;
#(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dii_packet_arbiter_if.slave   bus
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_r;
    logic [GW-1:0] grant_r;
    logic [GW-1:0] rr_ptr_r;
    dii_flit       out_r;

    logic [N-1:0]  req_s;
    logic [N-1:0]  sel_oh_s;
    logic          sel_any_s;
    logic [GW-1:0] sel_idx_s;
    logic [GW-1:0] ptr_next_s;
    logic [N-1:0]  in_ready_s;
    dii_flit       g_flit_s;
    logic          out_free_s;
    logic          accept_s;

    // Collect per-channel valid bits as the arbitration request vector.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < N; i++) begin
            req_s[i] = bus.in_flit[i].valid;
        end
    end

    dii_rr_select #(
        .N  (N),
        .PW (GW)
    ) u_rr_select (
        .req   (req_s),
        .ptr   (rr_ptr_r),
        .grant (sel_oh_s),
        .any   (sel_any_s)
    );

    // Encode the one-hot winner to an index (at most one bit is set).
    always_comb begin
        sel_idx_s = '0;
        for (int k = 0; k < N; k++) begin
            sel_idx_s = sel_idx_s | (sel_oh_s[k] ? GW'(k) : '0);
        end
    end

    // Handshake: only the granted channel may transfer, and only when the
    // output register is empty or being drained this cycle.
    always_comb begin
        g_flit_s   = bus.in_flit[grant_r];
        out_free_s = !out_r.valid || bus.out_ready;
        in_ready_s = '0;
        if (state_r == LOCKED) begin
            in_ready_s[grant_r] = out_free_s;
        end else begin
            in_ready_s = '0;
        end
        accept_s   = (state_r == LOCKED) && g_flit_s.valid && out_free_s;
        ptr_next_s = (grant_r == GW'(N - 1)) ? '0 : grant_r + GW'(1);
    end

    // Arbitration FSM plus the registered output flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            out_r    <= dii_assemble(1'b0, 1'b0, 16'h0000);
        end else begin
            case (state_r)
                IDLE: begin
                    if (sel_any_s) begin
                        grant_r <= sel_idx_s;
                        state_r <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Grant is released only by an accepted last flit;
                    // a valid gap mid-packet keeps waiting here.
                    if (accept_s && g_flit_s.last) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= ptr_next_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            if (accept_s) begin
                out_r <= dii_assemble(1'b1, g_flit_s.last, g_flit_s.data);
            end else if (out_r.valid && bus.out_ready) begin
                out_r <= dii_assemble(1'b0, 1'b0, 16'h0000);
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.out_flit = out_r;

endmodule
